// File: rtl/isa_ctrl_pkg.sv
// rtl/isa_ctrl_pkg.sv - shared types, register map and status packing for the ISA command issuer
package isa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_INSTR  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [7:0] level);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]               = busy;
    s[STAT_FULL]               = full;
    s[STAT_EMPTY]              = empty;
    s[STAT_OVF]                = ovf;
    s[STAT_LEVEL_LSB +: 8]     = level;
    return s;
  endfunction

endpackage

// File: rtl/isa_cmd_issuer_if.sv
// rtl/isa_cmd_issuer_if.sv - register-slave and executor signals of the ISA command issuer
interface isa_cmd_issuer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  reg_wr_en;
  logic [1:0]            reg_wr_idx;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [31:0]           status;
  logic [CNT_WIDTH-1:0]  issued_cnt;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic                  instr_ready;
  logic                  exec_done;
  logic                  irq;

  modport master (
    output reg_wr_en, reg_wr_idx, reg_wr_data, instr_ready, exec_done,
    input  status, issued_cnt, instr_valid, instr_data, irq
  );

  modport slave (
    input  reg_wr_en, reg_wr_idx, reg_wr_data, instr_ready, exec_done,
    output status, issued_cnt, instr_valid, instr_data, irq
  );
endinterface

// File: rtl/isa_sync_fifo.sv
// rtl/isa_sync_fifo.sv - flop-based synchronous FIFO with flush and occupancy level
module isa_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // Caller guarantees push only when not full (or popping) and pop only when not empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/isa_cmd_issuer.sv
// rtl/isa_cmd_issuer.sv - buffers instruction words from register writes and issues them one at a time
module isa_cmd_issuer
  import isa_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic              ACLK,
  input logic              ARESET,
  isa_cmd_issuer_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t                state;
  state_t                state_next;
  logic                  wr_ctrl;
  logic                  wr_instr;
  logic                  cmd_start;
  logic                  cmd_clear;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  irq_next;
  logic                  ovf;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LW-1:0]         fifo_level;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] instr_data_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  irq_q;

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_instr = 1'b0;
    if (bus.reg_wr_en) begin
      case (bus.reg_wr_idx)
        REG_CTRL:   wr_ctrl  = 1'b1;
        REG_INSTR:  wr_instr = 1'b1;
        REG_STATUS: wr_ctrl  = 1'b0;
        REG_COUNT:  wr_ctrl  = 1'b0;
      endcase
    end
  end

  assign cmd_start = wr_ctrl & bus.reg_wr_data[CTRL_START];
  assign cmd_clear = wr_ctrl & bus.reg_wr_data[CTRL_CLEAR];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign pop  = (state == ISSUE) & bus.instr_ready & ~cmd_clear;
  assign push = wr_instr & (~fifo_full | pop);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    irq_next   = 1'b0;
    if (cmd_clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start && !fifo_empty) begin
            state_next = ISSUE;
            load       = 1'b1;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            state_next = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.exec_done) begin
            if (fifo_empty) begin
              state_next = IDLE;
              irq_next   = 1'b1;
            end else begin
              state_next = ISSUE;
              load       = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      instr_data_q <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state <= state_next;
      irq_q <= irq_next;
      if (load) begin
        instr_data_q <= fifo_head;
      end
      if (cmd_clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (pop) begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
        if (wr_instr && fifo_full && !pop) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  isa_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push       (push),
    .push_data  (bus.reg_wr_data),
    .pop        (pop),
    .flush      (cmd_clear),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  assign bus.instr_valid = (state == ISSUE);
  assign bus.instr_data  = instr_data_q;
  assign bus.irq         = irq_q;
  assign bus.issued_cnt  = cnt;
  assign bus.status      = pack_status(state != IDLE, fifo_full, fifo_empty, ovf, 8'(fifo_level));

endmodule
